// File: rtl/mips_data_ram_model.sv
// Behavioural data RAM for MIPS core benches: Avalon-style waitrequest handshake,
// byte-lane writes, relocatable window, arithmetic-series preload, sticky error flag.
module mips_data_ram_model #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 0,
    parameter int          INIT_COUNT  = 15,
    parameter logic [31:0] INIT_BASE   = 32'h1234_5678,
    parameter logic [31:0] INIT_STEP   = 32'hDCBA_1234,
    parameter bit          INIT_SWAP   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic        data_waitrequest,
    output logic [31:0] data_readdata,
    output logic        data_error
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [3:0]    cnt;
    logic          req;
    logic          waiting;
    logic          complete;
    logic          below;
    logic          out_of_range;
    logic          bad;
    logic          rd_ok;
    logic          wr_ok;
    logic [29:0]   word_off;
    logic [AW-1:0] idx;
    logic [31:0]   words [DEPTH_WORDS];

    assign req              = data_read | data_write;
    assign waiting          = req && (int'(cnt) < WAIT_CYCLES);
    assign data_waitrequest = waiting;
    // cnt is held at 0 in reset, so a zero-wait access could otherwise complete there
    assign complete         = req & ~waiting & reset_n;

    assign word_off     = data_address[31:2] - ADDR_BASE[31:2];
    assign below        = data_address < ADDR_BASE;
    assign out_of_range = below | (word_off >= 30'(DEPTH_WORDS));
    assign bad          = (data_read & data_write) | (|data_address[1:0]) | out_of_range;
    assign idx          = word_off[AW-1:0];

    assign rd_ok         = complete & data_read & ~bad;
    assign wr_ok         = complete & data_write & ~bad;
    assign data_readdata = rd_ok ? words[idx] : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= 4'd0;
            data_error <= 1'b0;
        end else begin
            cnt <= waiting ? cnt + 4'd1 : 4'd0;
            // bad completion, or request dropped while a wait was in progress
            if ((complete & bad) | (~req & (cnt != 4'd0)))
                data_error <= 1'b1;
        end
    end

    // One register per word so each can carry its own power-up preload value.
    for (genvar k = 0; k < DEPTH_WORDS; k++) begin : g_word
        localparam logic [31:0] TERM    = INIT_BASE + INIT_STEP * 32'(k);
        localparam logic [31:0] PRELOAD = INIT_SWAP ?
            {TERM[7:0], TERM[15:8], TERM[23:16], TERM[31:24]} : TERM;

        logic [31:0] word = (k < INIT_COUNT) ? PRELOAD : 'x;

        always_ff @(posedge clk) begin
            if (wr_ok && (idx == AW'(k))) begin
                for (int b = 0; b < 4; b++)
                    if (data_byteenable[b])
                        word[8*b +: 8] <= data_writedata[8*b +: 8];
            end
        end

        assign words[k] = word;
    end
endmodule

// File: tb/tb_mips_data_ram_model.sv
// Directed bench for mips_data_ram_model: three instances covering zero-wait,
// 3-wait and 4-wait/relocated configurations.
module tb_mips_data_ram_model;
    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  be    [3];
    logic        wreq  [3];
    logic [31:0] rdat  [3];
    logic        err   [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_data_ram_model #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset_n(rst_n[0]), .data_address(addr[0]), .data_read(rd[0]),
        .data_write(wr[0]), .data_writedata(wdata[0]), .data_byteenable(be[0]),
        .data_waitrequest(wreq[0]), .data_readdata(rdat[0]), .data_error(err[0]));

    mips_data_ram_model #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset_n(rst_n[1]), .data_address(addr[1]), .data_read(rd[1]),
        .data_write(wr[1]), .data_writedata(wdata[1]), .data_byteenable(be[1]),
        .data_waitrequest(wreq[1]), .data_readdata(rdat[1]), .data_error(err[1]));

    mips_data_ram_model #(.WAIT_CYCLES(4), .ADDR_BASE(32'h1000_0000)) u_w4 (
        .clk(clk), .reset_n(rst_n[2]), .data_address(addr[2]), .data_read(rd[2]),
        .data_write(wr[2]), .data_writedata(wdata[2]), .data_byteenable(be[2]),
        .data_waitrequest(wreq[2]), .data_readdata(rdat[2]), .data_error(err[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the completion edge
    // with the request dropped.
    task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b,
                          output int waits, output logic [31:0] rdata);
        bit done = 1'b0;
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        waits = 0;
        rdata = 32'h0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!wreq[d]) begin
                rdata = rdat[d];
                done  = 1'b1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        if (!done) chk("access_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    initial begin
        int          n;
        logic [31:0] q;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
            addr[i] = 32'h0; wdata[i] = 32'h0; be[i] = 4'h0;
        end
        rd[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_err0", err[0], 1'b0);
        chk("rst_wreq0", wreq[0], 1'b0);
        chk("rst_rdat0", rdat[0], 32'h0);
        chk("rst_wreq_w3", wreq[1], 1'b1);
        chk("rst_rdat_w3", rdat[1], 32'h0);
        rd[1] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(posedge clk); #1;

        // zero-wait instance
        access(0, 1, 0, 32'h0, 32'h0, 4'h0, n, q);
        chk("w0_rd0_waits", n, 0);
        chk("w0_rd0", q, 32'h7856_3412);
        access(0, 1, 0, 32'h4, 32'h0, 4'h0, n, q);
        chk("w0_rd4_waits", n, 0);
        chk("w0_rd4", q, 32'hAC68_EEEE);
        access(0, 0, 1, 32'h0, 32'hAABB_CCDD, 4'b0101, n, q);
        chk("w0_wr_waits", n, 0);
        access(0, 1, 0, 32'h0, 32'h0, 4'h0, n, q);
        chk("w0_lane_wr", q, 32'h78BB_34DD);
        access(0, 0, 1, 32'h0, 32'h1111_1111, 4'b0000, n, q);
        access(0, 1, 0, 32'h0, 32'h0, 4'h0, n, q);
        chk("w0_be0_nochange", q, 32'h78BB_34DD);
        chk("w0_err_clean", err[0], 1'b0);
        access(0, 0, 1, 32'h2, 32'hFFFF_FFFF, 4'hF, n, q);
        @(negedge clk);
        chk("w0_misalign_err", err[0], 1'b1);
        @(posedge clk); #1;
        access(0, 1, 0, 32'h0, 32'h0, 4'h0, n, q);
        chk("w0_misalign_nowr", q, 32'h78BB_34DD);
        access(0, 1, 1, 32'h4, 32'h0, 4'hF, n, q);
        chk("w0_rdwr_rdat", q, 32'h0);
        access(0, 1, 0, 32'h4, 32'h0, 4'h0, n, q);
        chk("w0_rdwr_nowr", q, 32'hAC68_EEEE);
        chk("w0_err_sticky", err[0], 1'b1);

        // three-wait instance, back-to-back accesses
        access(1, 1, 0, 32'h8, 32'h0, 4'h0, n, q);
        chk("w3_rd8_waits", n, 3);
        chk("w3_rd8", q, 32'hE07A_A8CB);
        access(1, 1, 0, 32'h0, 32'h0, 4'h0, n, q);
        chk("w3_b2b_waits", n, 3);
        chk("w3_b2b", q, 32'h7856_3412);
        access(1, 0, 1, 32'hC, 32'h0BAD_F00D, 4'hF, n, q);
        chk("w3_wr_waits", n, 3);
        access(1, 1, 0, 32'hC, 32'h0, 4'h0, n, q);
        chk("w3_raw", q, 32'h0BAD_F00D);
        chk("w3_err_clean", err[1], 1'b0);
        rd[1] = 1'b1; addr[1] = 32'h0;
        @(posedge clk); #1;
        rd[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("w3_abandon_err", err[1], 1'b1);
        @(posedge clk); #1;

        // four-wait relocated instance: reset mid-wait
        rd[2] = 1'b1; addr[2] = 32'h1000_0000;
        @(negedge clk);
        chk("w4_c0_wreq", wreq[2], 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        @(negedge clk);
        chk("w4_rst_wreq", wreq[2], 1'b1);
        chk("w4_rst_rdat", rdat[2], 32'h0);
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        access(2, 1, 0, 32'h1000_0000, 32'h0, 4'h0, n, q);
        chk("w4_restart_waits", n, 4);
        chk("w4_restart_rd", q, 32'h7856_3412);
        chk("w4_restart_err", err[2], 1'b0);
        access(2, 1, 0, 32'h0FFF_FFFC, 32'h0, 4'h0, n, q);
        chk("w4_below_rdat", q, 32'h0);
        chk("w4_below_err", err[2], 1'b1);
        access(2, 1, 0, 32'h1000_4000, 32'h0, 4'h0, n, q);
        chk("w4_above_rdat", q, 32'h0);
        access(2, 1, 0, 32'h1000_0004, 32'h0, 4'h0, n, q);
        chk("w4_inwin_rd", q, 32'hAC68_EEEE);
        chk("w4_err_sticky", err[2], 1'b1);
        rst_n[2] = 1'b0;
        @(negedge clk);
        chk("w4_err_cleared", err[2], 1'b0);
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        access(2, 1, 0, 32'h1000_0004, 32'h0, 4'h0, n, q);
        chk("w4_mem_survives_rst", q, 32'hAC68_EEEE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
